bcd_counter_n: RTL and testbench

Parametrised N-digit BCD up/down counter. It replaces the chain of single-digit ripple-clocked decimal counters with one fully synchronous block.
- Drives the score field of the 7-segment scan path. Each 4-bit digit maps directly to one display position.
- Adds decrement, parallel load, wrap/saturate mode, terminal-count flags and a sticky overflow flag.

---
 rtl/bcd_counter_n_pkg.sv | 20 ++
 rtl/bcd_digit.sv | 32 +++
 rtl/bcd_counter_n.sv | 101 ++++++++++
 tb/tb_bcd_counter_n.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_counter_n_pkg.sv
// Shared definitions for the N-digit BCD counter: digit width, digit bound,
// command opcodes and a load-value clamp helper.
package bcd_counter_n_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_INC,
    OP_DEC,
    OP_LOAD
  } op_e;

  // Any non-decimal nibble loads as 9.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit register with load, count-up and count-down carry inputs.
module bcd_digit
  import bcd_counter_n_pkg::*;
(
  input  logic             clk,
  input  logic             clr_n,
  input  logic             ci_up,
  input  logic             ci_dn,
  input  logic             load,
  input  logic [BCD_W-1:0] load_digit,
  output logic [BCD_W-1:0] digit,
  output logic             is9,
  output logic             is0
);

  assign is9 = (digit == BCD_MAX);
  assign is0 = (digit == '0);

  // Digit state: load has priority, then up, then down; wraps stay within 0..9.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      digit <= '0;
    end else if (load) begin
      digit <= bcd_clamp(load_digit);
    end else if (ci_up) begin
      digit <= is9 ? '0 : digit + 4'd1;
    end else if (ci_dn) begin
      digit <= is0 ? BCD_MAX : digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_counter_n.sv
// N-digit synchronous BCD up/down counter with load, wrap/saturate mode,
// terminal-count flags, registered carry/borrow pulses and sticky overflow.
module bcd_counter_n
  import bcd_counter_n_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter bit          WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  en,
  input  logic                  inc,
  input  logic                  dec,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  carry_out,
  output logic                  borrow_out,
  output logic                  at_max,
  output logic                  at_zero,
  output logic                  ovf
);

  op_e               op;
  logic [DIGITS-1:0] is9;
  logic [DIGITS-1:0] is0;
  logic [DIGITS-1:0] lo9;
  logic [DIGITS-1:0] lo0;
  logic [DIGITS-1:0] ci_up;
  logic [DIGITS-1:0] ci_dn;
  logic              step_up;
  logic              step_dn;

  assign at_max  = &is9;
  assign at_zero = &is0;

  // Command priority decode: load, then exclusive inc/dec, else hold.
  always_comb begin
    op = OP_HOLD;
    if (en) begin
      if (load)             op = OP_LOAD;
      else if (inc && !dec) op = OP_INC;
      else if (dec && !inc) op = OP_DEC;
    end
  end

  // In saturate mode a step past the bound is suppressed entirely.
  assign step_up = (op == OP_INC) && (WRAP || !at_max);
  assign step_dn = (op == OP_DEC) && (WRAP || !at_zero);

  // All-lower-digits-9 / all-lower-digits-0 chains gating each digit's step.
  always_comb begin
    logic acc9;
    logic acc0;
    acc9 = 1'b1;
    acc0 = 1'b1;
    lo9  = '0;
    lo0  = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      lo9[i] = acc9;
      lo0[i] = acc0;
      acc9   = acc9 & is9[i];
      acc0   = acc0 & is0[i];
    end
  end

  assign ci_up = {DIGITS{step_up}} & lo9;
  assign ci_dn = {DIGITS{step_dn}} & lo0;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .clr_n      (clr_n),
      .ci_up      (ci_up[g]),
      .ci_dn      (ci_dn[g]),
      .load       (op == OP_LOAD),
      .load_digit (load_val[g*BCD_W +: BCD_W]),
      .digit      (count[g*BCD_W +: BCD_W]),
      .is9        (is9[g]),
      .is0        (is0[g])
    );
  end

  // Boundary flags: one-cycle wrap pulses and sticky overflow cleared by load.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      carry_out  <= 1'b0;
      borrow_out <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      carry_out  <= WRAP && (op == OP_INC) && at_max;
      borrow_out <= WRAP && (op == OP_DEC) && at_zero;
      if (op == OP_LOAD) begin
        ovf <= 1'b0;
      end else if (((op == OP_INC) && at_max) || ((op == OP_DEC) && at_zero)) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_counter_n.sv
// Self-checking bench for bcd_counter_n: decimal-integer model for a wrapping
// and a saturating 4-digit instance, plus a cascaded pair of 1-digit counters.
module tb_bcd_counter_n;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        en = 1'b0;
  logic        inc = 1'b0;
  logic        dec = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val = '0;

  logic [15:0] cnt_w, cnt_s;
  logic        co_w, bo_w, mx_w, zr_w, ov_w;
  logic        co_s, bo_s, mx_s, zr_s, ov_s;

  logic        cinc = 1'b0;
  logic [3:0]  lo_cnt, hi_cnt;
  logic        lo_co, lo_bo, lo_mx, lo_zr, lo_ov;
  logic        hi_co, hi_bo, hi_mx, hi_zr, hi_ov;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_counter_n #(.DIGITS(4), .WRAP(1'b1)) u_wrap (
    .clk(clk), .clr_n(clr_n), .en(en), .inc(inc), .dec(dec), .load(load),
    .load_val(load_val), .count(cnt_w), .carry_out(co_w), .borrow_out(bo_w),
    .at_max(mx_w), .at_zero(zr_w), .ovf(ov_w)
  );

  bcd_counter_n #(.DIGITS(4), .WRAP(1'b0)) u_sat (
    .clk(clk), .clr_n(clr_n), .en(en), .inc(inc), .dec(dec), .load(load),
    .load_val(load_val), .count(cnt_s), .carry_out(co_s), .borrow_out(bo_s),
    .at_max(mx_s), .at_zero(zr_s), .ovf(ov_s)
  );

  bcd_counter_n #(.DIGITS(1), .WRAP(1'b1)) u_lo (
    .clk(clk), .clr_n(clr_n), .en(1'b1), .inc(cinc), .dec(1'b0), .load(1'b0),
    .load_val(4'h0), .count(lo_cnt), .carry_out(lo_co), .borrow_out(lo_bo),
    .at_max(lo_mx), .at_zero(lo_zr), .ovf(lo_ov)
  );

  bcd_counter_n #(.DIGITS(1), .WRAP(1'b1)) u_hi (
    .clk(clk), .clr_n(clr_n), .en(1'b1), .inc(lo_co), .dec(1'b0), .load(1'b0),
    .load_val(4'h0), .count(hi_cnt), .carry_out(hi_co), .borrow_out(hi_bo),
    .at_max(hi_mx), .at_zero(hi_zr), .ovf(hi_ov)
  );

  // ---------------- behavioural model (decimal integer) ----------------
  typedef struct {
    int val;
    bit carry;
    bit borrow;
    bit ovf;
  } mstate_t;

  mstate_t mw = '{0, 1'b0, 1'b0, 1'b0};
  mstate_t ms = '{0, 1'b0, 1'b0, 1'b0};

  function automatic int load_to_int(input logic [15:0] lv);
    int v = 0;
    int w = 1;
    logic [3:0] d;
    for (int k = 0; k < 4; k++) begin
      d = lv[4*k +: 4];
      if (d > 4'd9) d = 4'd9;
      v = v + int'(d) * w;
      w = w * 10;
    end
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    int t = v;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic mstate_t mnext(input mstate_t s, input bit wrap, input bit e,
                                    input bit i, input bit d, input bit l,
                                    input logic [15:0] lv);
    mstate_t n = s;
    n.carry  = 1'b0;
    n.borrow = 1'b0;
    if (!e) return n;
    if (l) begin
      n.val = load_to_int(lv);
      n.ovf = 1'b0;
    end else if (i && !d) begin
      if (s.val == 9999) begin
        n.ovf = 1'b1;
        if (wrap) begin n.val = 0; n.carry = 1'b1; end
      end else begin
        n.val = s.val + 1;
      end
    end else if (d && !i) begin
      if (s.val == 0) begin
        n.ovf = 1'b1;
        if (wrap) begin n.val = 9999; n.borrow = 1'b1; end
      end else begin
        n.val = s.val - 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      mw <= '{0, 1'b0, 1'b0, 1'b0};
      ms <= '{0, 1'b0, 1'b0, 1'b0};
    end else begin
      mw <= mnext(mw, 1'b1, en, inc, dec, load, load_val);
      ms <= mnext(ms, 1'b0, en, inc, dec, load, load_val);
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("w.count",  32'(cnt_w), 32'(to_bcd(mw.val)));
    chk("w.carry",  32'(co_w),  32'(mw.carry));
    chk("w.borrow", 32'(bo_w),  32'(mw.borrow));
    chk("w.ovf",    32'(ov_w),  32'(mw.ovf));
    chk("w.at_max", 32'(mx_w),  32'(mw.val == 9999));
    chk("w.at_zero",32'(zr_w),  32'(mw.val == 0));
    chk("s.count",  32'(cnt_s), 32'(to_bcd(ms.val)));
    chk("s.carry",  32'(co_s),  32'(ms.carry));
    chk("s.borrow", 32'(bo_s),  32'(ms.borrow));
    chk("s.ovf",    32'(ov_s),  32'(ms.ovf));
    chk("s.at_max", 32'(mx_s),  32'(ms.val == 9999));
    chk("s.at_zero",32'(zr_s),  32'(ms.val == 0));
    chk("w.pulse_excl", 32'(co_w & bo_w), 32'(0));
  end

  // Drive one command for exactly one edge, then return to idle (en=1).
  task automatic apply(input bit e, input bit i, input bit d, input bit l,
                       input logic [15:0] lv);
    en = e; inc = i; dec = d; load = l; load_val = lv;
    @(posedge clk); #1;
    en = 1'b1; inc = 1'b0; dec = 1'b0; load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst.count",  32'(cnt_w), 32'h0);
    chk("rst.at_zero",32'(zr_w),  32'h1);
    chk("rst.at_max", 32'(mx_w),  32'h0);
    chk("rst.ovf",    32'(ov_w),  32'h0);
    clr_n = 1'b1;
    en    = 1'b1;

    // 12 increments
    for (int n = 0; n < 12; n++) apply(1, 1, 0, 0, 16'h0);
    chk("inc12.count",   32'(cnt_w), 32'h0012);
    chk("inc12.ovf",     32'(ov_w),  32'h0);
    chk("inc12.at_zero", 32'(zr_w),  32'h0);

    // asynchronous reset in the middle of an inc pulse
    inc = 1'b1;
    #3;
    clr_n = 1'b0;
    #1;
    chk("async_rst.count_w", 32'(cnt_w), 32'h0);
    chk("async_rst.count_s", 32'(cnt_s), 32'h0);
    @(posedge clk); #1;
    inc   = 1'b0;
    clr_n = 1'b1;

    // upper boundary: wrap vs saturate
    apply(1, 0, 0, 1, 16'h9998);
    apply(1, 1, 0, 0, 16'h0);
    chk("up1.w", 32'(cnt_w), 32'h9999);
    chk("up1.s", 32'(cnt_s), 32'h9999);
    chk("up1.s_ovf", 32'(ov_s), 32'h0);
    apply(1, 1, 0, 0, 16'h0);
    chk("up2.w", 32'(cnt_w), 32'h0000);
    chk("up2.w_carry", 32'(co_w), 32'h1);
    chk("up2.s", 32'(cnt_s), 32'h9999);
    chk("up2.s_ovf", 32'(ov_s), 32'h1);
    apply(1, 1, 0, 0, 16'h0);
    chk("up3.w", 32'(cnt_w), 32'h0001);
    chk("up3.w_carry", 32'(co_w), 32'h0);
    chk("up3.w_ovf", 32'(ov_w), 32'h1);
    chk("up3.s", 32'(cnt_s), 32'h9999);

    // decrement across a digit boundary and lower boundary
    apply(1, 0, 0, 1, 16'h0100);
    apply(1, 0, 1, 0, 16'h0);
    chk("dec.0099", 32'(cnt_w), 32'h0099);
    apply(1, 0, 0, 1, 16'h0000);
    apply(1, 0, 1, 0, 16'h0);
    chk("lo.w", 32'(cnt_w), 32'h9999);
    chk("lo.w_borrow", 32'(bo_w), 32'h1);
    chk("lo.w_ovf", 32'(ov_w), 32'h1);
    chk("lo.s", 32'(cnt_s), 32'h0000);
    chk("lo.s_ovf", 32'(ov_s), 32'h1);

    // held dec into the saturating floor
    apply(1, 0, 0, 1, 16'h0003);
    for (int n = 0; n < 5; n++) apply(1, 0, 1, 0, 16'h0);
    chk("hold_dec.s", 32'(cnt_s), 32'h0000);
    chk("hold_dec.w", 32'(cnt_w), 32'h9998);

    // clamped load, inc+dec no-op, disabled load/inc
    apply(1, 0, 0, 1, 16'h3A5F);
    chk("clamp.count", 32'(cnt_w), 32'h3959);
    chk("clamp.ovf",   32'(ov_w),  32'h0);
    apply(1, 1, 1, 0, 16'h0);
    chk("incdec.count", 32'(cnt_w), 32'h3959);
    apply(0, 0, 0, 1, 16'h1234);
    chk("en0_load.count", 32'(cnt_w), 32'h3959);
    apply(0, 1, 0, 0, 16'h0);
    chk("en0_inc.count", 32'(cnt_w), 32'h3959);
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // cascade of two 1-digit counters, 25 held inc cycles
    cinc = 1'b1;
    for (int p = 1; p <= 25; p++) begin
      @(posedge clk); #1;
      if (p == 10) begin
        chk("casc10.lo", 32'(lo_cnt), 32'h0);
        chk("casc10.carry", 32'(lo_co), 32'h1);
        chk("casc10.hi", 32'(hi_cnt), 32'h0);
      end
      if (p == 11) chk("casc11.hi", 32'(hi_cnt), 32'h1);
    end
    cinc = 1'b0;
    @(posedge clk); #1;
    chk("casc.value", 32'(int'(hi_cnt) * 10 + int'(lo_cnt)), 32'd25);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
